// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: NOP encoding, fetch FSM states and default reset PC.
package riscv_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // RUN: nothing outstanding, WAIT: one response due, DROP: one stale response to discard
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Bus bundle between the fetch stage, instruction memory, redirect source and decode.
interface fetch_stage_if #(
    parameter int DATA_WIDTH = 32
);
    // imem: a request is issued on the cycle imem_req && imem_gnt; imem_rvalid returns its word later.
    // id: an instruction transfers on id_valid && id_ready; id_inst/id_pc hold while stalled.
    logic                  imem_req;
    logic [DATA_WIDTH-1:0] imem_addr;
    logic                  imem_gnt;
    logic                  imem_rvalid;
    logic [31:0]           imem_rdata;
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  id_valid;
    logic                  id_ready;
    logic [31:0]           id_inst;
    logic [DATA_WIDTH-1:0] id_pc;

    modport master (
        output imem_req, imem_addr, id_valid, id_inst, id_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_inst, id_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_buffer.sv
// Two-entry response FIFO between instruction memory and decode; flush empties it in one cycle.
module fetch_buffer #(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= RESET_VAL;
            mem[1] <= RESET_VAL;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= !wr_ptr;
            end
            if (do_pop) rd_ptr <= !rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: single-outstanding imem requester feeding decode through fetch_buffer.
// Define FETCH_STATS_EN to add the fetch_count / stall_count performance counters.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus,
    output fetch_state_e  dbg_state
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]   fetch_count,
    output logic [31:0]   stall_count
`endif
);
    localparam int ENTRY_W = DATA_WIDTH + 32;

    fetch_state_e          state, state_n;
    logic [DATA_WIDTH-1:0] pc, pc_n;
    logic [DATA_WIDTH-1:0] req_pc, req_pc_n;
    logic                  started;
    logic                  buf_full, buf_empty;
    logic                  push, pop, issue;
    logic [ENTRY_W-1:0]    head;
    logic [2:0]            occ, load;

    fetch_buffer #(
        .WIDTH    (ENTRY_W),
        .RESET_VAL({DATA_WIDTH'(0), NOP_INST})
    ) u_buf (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .pop  (pop),
        .flush(bus.redirect_valid),
        .wdata({req_pc, bus.imem_rdata}),
        .rdata(head),
        .full (buf_full),
        .empty(buf_empty)
    );

    assign bus.id_valid  = !buf_empty;
    assign bus.id_pc     = head[ENTRY_W-1:32];
    assign bus.id_inst   = head[31:0];
    assign bus.imem_addr = pc;
    assign pop           = bus.id_valid && bus.id_ready;
    assign dbg_state     = state;

    // started holds the request low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RUN;
            pc      <= RESET_PC;
            req_pc  <= RESET_PC;
            started <= 1'b0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            req_pc  <= req_pc_n;
            started <= 1'b1;
        end
    end

    always_comb begin
        occ  = buf_full ? 3'd2 : (buf_empty ? 3'd0 : 3'd1);
        // Slots already claimed after this cycle's pop; in WAIT a new request may only ride on rvalid.
        load = occ + ((state == ST_WAIT) ? 3'd1 : 3'd0) - (pop ? 3'd1 : 3'd0);
        bus.imem_req = started && (state != ST_DROP) && (load < 3'd2)
                       && ((state == ST_RUN) || bus.imem_rvalid);
        issue    = bus.imem_req && bus.imem_gnt;
        push     = (state == ST_WAIT) && bus.imem_rvalid && !bus.redirect_valid;
        state_n  = state;
        pc_n     = pc;
        req_pc_n = req_pc;
        if (issue) begin
            pc_n     = pc + DATA_WIDTH'(4);
            req_pc_n = pc;
        end
        if (bus.redirect_valid) begin
            pc_n    = bus.redirect_pc & ~DATA_WIDTH'(3);
            state_n = (issue || ((state != ST_RUN) && !bus.imem_rvalid)) ? ST_DROP : ST_RUN;
        end else begin
            case (state)
                ST_RUN:  if (issue) state_n = ST_WAIT;
                ST_WAIT: if (bus.imem_rvalid) state_n = issue ? ST_WAIT : ST_RUN;
                ST_DROP: if (bus.imem_rvalid) state_n = ST_RUN;
                default: state_n = ST_RUN;
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            if (pop) fetch_count <= fetch_count + 32'd1;
            if (bus.id_ready && !bus.id_valid) stall_count <= stall_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: random memory/decode/redirect traffic checked against an address-stream model.
module tb_fetch_stage;
  import riscv_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fetch_stage_if #(.DATA_WIDTH(W)) bus ();
  fetch_state_e dbg_state;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  fetch_stage #(.DATA_WIDTH(W), .RESET_PC(32'h0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count (fetch_count),
    .stall_count (stall_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Decode must see target, target+4, ... with the memory contents at those addresses.
  logic [63:0] exp_q[$];

  task automatic rebuild(input logic [31:0] start);
    logic [31:0] a;
    exp_q.delete();
    for (int i = 0; i < 512; i++) begin
      a = start + 32'(4 * i);
      exp_q.push_back({a, mem_word(a)});
    end
  endtask

  // ---------------- memory driver ----------------
  int          gnt_pct = 100;
  int          max_lat = 0;
  int          ready_pct = 100;
  bit          pend_valid = 1'b0;
  logic [31:0] pend_addr;
  int          pend_wait;

  always begin
    @(posedge clk);
    #1;
    bus.imem_gnt = ($urandom_range(0, 99) < gnt_pct);
    if (!rst_n) begin
      pend_valid = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata = 32'h0;
    end else if (pend_valid && pend_wait == 0) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = mem_word(pend_addr);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata = $urandom;
      if (pend_valid) pend_wait--;
    end
    @(negedge clk);
    if (rst_n) begin
      if (bus.imem_rvalid) pend_valid = 1'b0;
      if (bus.imem_req && bus.imem_gnt) begin
        check("one_outstanding", 64'(pend_valid), 64'd0);
        pend_valid = 1'b1;
        pend_addr  = bus.imem_addr;
        pend_wait  = $urandom_range(0, max_lat);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int          hs_count = 0;
  int          model_fetch = 0;
  int          model_stall = 0;
  bit          hold_chk = 1'b0;
  logic [63:0] hold_val;
  bit          addr_chk = 1'b0;
  logic [31:0] addr_val;
  logic [63:0] mon_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_chk    = 1'b0;
      addr_chk    = 1'b0;
      model_fetch = 0;
      model_stall = 0;
    end else begin
      if (bus.id_valid && bus.id_ready) begin
        hs_count++;
        model_fetch++;
        if (exp_q.size() == 0) fail("sb_underflow");
        else begin
          mon_exp = exp_q.pop_front();
          check("id_pc", 64'(bus.id_pc), 64'(mon_exp[63:32]));
          check("id_inst", 64'(bus.id_inst), 64'(mon_exp[31:0]));
        end
      end
      if (bus.id_ready && !bus.id_valid) model_stall++;
      if (hold_chk) begin
        check("hold_valid", 64'(bus.id_valid), 64'd1);
        check("hold_data", {bus.id_pc, bus.id_inst}, hold_val);
      end
      hold_chk = bus.id_valid && !bus.id_ready && !bus.redirect_valid;
      hold_val = {bus.id_pc, bus.id_inst};
      if (addr_chk && bus.imem_req) check("addr_stable", 64'(bus.imem_addr), 64'(addr_val));
      addr_chk = bus.imem_req && !bus.imem_gnt && !bus.redirect_valid;
      addr_val = bus.imem_addr;
      if (bus.imem_req) check("addr_align", 64'(bus.imem_addr[1:0]), 64'd0);
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.id_ready = ($urandom_range(0, 99) < ready_pct);
    end
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    bus.redirect_pc = tgt;
    bus.redirect_valid = 1'b1;
    @(posedge clk);
    rebuild(tgt & ~32'h3);
    #1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = $urandom;
  endtask

  task automatic run_random(input int n);
    logic [31:0] tgt;
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.id_ready = ($urandom_range(0, 99) < ready_pct);
      if ($urandom_range(0, 99) < 5) begin
        tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
        do_redirect(tgt);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"}, 64'(bus.imem_req), 64'd0);
    check({tag, "_id_valid"}, 64'(bus.id_valid), 64'd0);
    check({tag, "_id_inst"}, 64'(bus.id_inst), 64'h13);
    check({tag, "_id_pc"}, 64'(bus.id_pc), 64'd0);
    check({tag, "_addr"}, 64'(bus.imem_addr), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'(ST_RUN));
  endtask

  task automatic release_and_check(input string tag);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check({tag, "_req_pre_edge"}, 64'(bus.imem_req), 64'd0);
    @(negedge clk);
    check({tag, "_req_post_edge"}, 64'(bus.imem_req), 64'd1);
    check({tag, "_first_addr"}, 64'(bus.imem_addr), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int  hs0;
    bit  found;
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.id_ready = 1'b1;
    rebuild(32'h0);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_reset_values("por");
    repeat (2) @(posedge clk);
    release_and_check("por");

    // streaming: always granted, one-cycle response, decode always ready
    hs0 = hs_count;
    run(20);
    check("stream_rate", 64'(hs_count - hs0 >= 10), 64'd1);

    // backpressure: decode stalls five cycles
    @(posedge clk);
    #1 bus.id_ready = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("bp_req_low", 64'(bus.imem_req), 64'd0);
    check("bp_id_valid", 64'(bus.id_valid), 64'd1);
    run(10);

    // redirect while a response is still outstanding
    max_lat = 3;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(posedge clk);
      #2;
      if (pend_valid && pend_wait > 0) found = 1'b1;
    end
    if (!found) fail("redir_setup");
    else begin
      do_redirect(32'h0000_0103);
      @(negedge clk);
      check("redir_addr", 64'(bus.imem_addr), 64'h100);
      check("redir_state", 64'(dbg_state), 64'(ST_DROP));
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
        @(negedge clk);
        if (bus.id_valid) begin
          check("redir_first_pc", 64'(bus.id_pc), 64'h100);
          found = 1'b1;
        end
      end
      if (!found) fail("redir_first_pc");
    end

    // address wrap
    max_lat = 0;
    @(posedge clk);
    #1 bus.id_ready = 1'b1;
    do_redirect(32'hFFFF_FFFC);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (bus.imem_req && bus.imem_gnt && bus.imem_addr == 32'hFFFF_FFFC) begin
        @(negedge clk);
        check("wrap_addr", 64'(bus.imem_addr), 64'd0);
        found = 1'b1;
      end
    end
    if (!found) fail("wrap_grant");

    // random traffic
    gnt_pct = 70;
    max_lat = 2;
    ready_pct = 70;
    run_random(1500);

    // reset in the middle of traffic
    @(posedge clk);
    #3 rst_n = 1'b0;
    rebuild(32'h0);
    @(negedge clk);
    check_reset_values("mid");
    release_and_check("mid");
    run_random(400);

    // drain
    ready_pct = 100;
    run(30);

`ifdef FETCH_STATS_EN
    begin
      logic [31:0] f0, s0;
      int          cnt;
      gnt_pct = 0;
      max_lat = 0;
      @(posedge clk);
      #1 bus.id_ready = 1'b0;
      repeat (6) @(posedge clk);
      #1 do_redirect(32'h0000_0200);
      @(negedge clk);
      f0 = fetch_count;
      s0 = stall_count;
      repeat (2) begin
        @(posedge clk);
        #1 bus.id_ready = 1'b1;
      end
      @(posedge clk);
      #1 bus.id_ready = 1'b0;
      gnt_pct = 100;
      repeat (6) @(posedge clk);
      cnt = 0;
      for (int c = 0; c < 40 && cnt < 3; c++) begin
        @(posedge clk);
        #1 bus.id_ready = bus.id_valid;
        if (bus.id_valid) cnt++;
      end
      if (cnt < 3) fail("stats_handshakes");
      @(posedge clk);
      #1 bus.id_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("fetch_count_delta", 64'(fetch_count - f0), 64'd3);
      check("stall_count_delta", 64'(stall_count - s0), 64'd2);
    end
`endif

    ready_pct = 0;
    run(4);
    @(negedge clk);
    check("total_handshakes", 64'(hs_count >= 200), 64'd1);
`ifdef FETCH_STATS_EN
    check("fetch_count_model", 64'(fetch_count), 64'(model_fetch));
    check("stall_count_model", 64'(stall_count), 64'(model_stall));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    fail("watchdog");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage
Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of PC and address paths.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port imem_req  output  1  fetch request valid.
REQ-006 SHALL have port imem_addr  output  DATA_WIDTH  fetch address, word aligned.
REQ-007 SHALL have port imem_gnt  input  1  request accepted this cycle.
REQ-008 SHALL have port imem_rvalid  input  1  read data valid.
REQ-009 SHALL have port imem_rdata  input  32  instruction word.
REQ-010 SHALL have ports redirect_valid  input  1 and redirect_pc  input  DATA_WIDTH  branch/jump target.
REQ-011 SHALL have port id_valid  output  1  instruction available to decode/immgen.
REQ-012 SHALL have port id_ready  input  1  decode accepts instruction.
REQ-013 SHALL have ports id_inst  output  32 and id_pc  output  DATA_WIDTH  instruction and its address.
Function
REQ-014 SHALL treat a request as issued only on imem_req && imem_gnt; at most one issued request outstanding.
REQ-015 SHALL hold imem_addr stable while imem_req && !imem_gnt, except on redirect.
REQ-016 SHALL buffer responses in a 2-entry FIFO; assert imem_req only when occupancy + outstanding < 2.
REQ-017 SHALL write imem_rdata into FIFO on imem_rvalid; id_valid rises the next cycle (1-cycle latency).
REQ-018 SHALL drive id_valid = FIFO non-empty, id_inst/id_pc = FIFO head; pop on id_valid && id_ready.
REQ-019 SHALL keep id_inst/id_pc stable while id_valid && !id_ready.
REQ-020 SHALL advance fetch PC by 4 on each grant, wrapping modulo 2^DATA_WIDTH.
REQ-021 SHALL implement FSM states RUN (no outstanding), WAIT (one outstanding), DROP (outstanding response to discard).
REQ-022 SHALL transition RUN->WAIT on grant; WAIT->RUN on rvalid without grant; WAIT stays WAIT on rvalid with grant.
REQ-023 SHALL, on redirect_valid: flush FIFO, load fetch PC with {redirect_pc[DATA_WIDTH-1:2],2'b00}, enter DROP if a request is outstanding else RUN.
REQ-024 SHALL, in DROP, discard the next rvalid and go to RUN; no request issued in DROP.
REQ-025 SHALL discard an rvalid coinciding with redirect_valid.
REQ-026 SHALL complete an id handshake coinciding with redirect_valid, then flush remaining entries.
REQ-027 SHALL give redirect priority over a same-cycle grant: granted request counted outstanding, goes to DROP.
REQ-028 SHALL let redirect change imem_addr while an ungranted request is pending.
Reset
REQ-029 SHALL on rst_n low drive imem_req=0, imem_addr=RESET_PC, id_valid=0, id_inst=32'h0000_0013, id_pc=0, FIFO empty, state RUN.
REQ-030 SHALL assert imem_req with RESET_PC on the first rising edge after rst_n deasserts; reset mid-transaction abandons any outstanding response.
Configuration
REQ-031 SHALL, with macro FETCH_STATS_EN defined, add outputs fetch_count and stall_count (32 bits, reset 0, wrapping).
REQ-032 SHALL increment fetch_count per id handshake and stall_count per cycle of id_ready && !id_valid.
REQ-033 SHALL, without FETCH_STATS_EN, have neither port nor counter logic; all other behaviour identical.
Structure
REQ-034 SHALL place NOP constant (32'h0000_0013), fetch state enum and default RESET_PC in shared package riscv_pkg.
REQ-035 SHALL implement the FIFO as sub-module fetch_buffer (depth 2, push/pop/flush, full/empty).
Verification
REQ-036 SHALL check reset: rst_n low mid-run -> imem_req=0, id_valid=0, id_inst=32'h13; release -> imem_addr=0 with req next edge.
REQ-037 SHALL check streaming: gnt always 1, rvalid 1 cycle later -> id_pc 0,4,8,12 consecutive, id_inst matches rdata.
REQ-038 SHALL check backpressure: id_ready=0 for 5 cycles -> imem_req drops after 2 buffered, id_inst stable, no loss.
REQ-039 SHALL check redirect with outstanding request: redirect_pc=32'h0000_0103 -> next addr 32'h100, stale rdata dropped, id_pc=32'h100.
REQ-040 SHALL check wrap: redirect to 32'hFFFF_FFFC -> following fetch addr 32'h0000_0000.
REQ-041 SHALL check FETCH_STATS_EN: 3 handshakes, 2 starved cycles -> fetch_count=3, stall_count=2.
